dii_host_packetizer: RTL

Converts the raw 16-bit host word stream arriving over GLIP into DII packets framed with a `last` marker. It sits on the host-to-chip path, directly upstream of the debug ring gateway's external-traffic input.
The host prefixes each packet with a length word. The block strips that header, forwards the payload flits, marks the final flit, and discards malformed packets (zero length, or longer than MAX_PKT_LEN) without stalling the link.
Output is registered through a 2-entry skid buffer, so the block sustains full throughput and breaks the combinational ready path.

---
 rtl/dii_package.sv | 27 ++
 rtl/dii_skid_buffer.sv | 71 +++++++
 rtl/dii_host_packetizer.sv | 108 ++++++++++
 3 files changed

// File: rtl/dii_package.sv
// Shared DII ring definitions: flit layout, header width, packetizer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   DII_DATA_W   - payload width of one flit
//   DII_HDR_W    - width of the host length header and the remaining-word counter
//   dii_flit     - {data, last, valid} as carried on ring ports
//   pktz_state_e - host packetizer FSM states
package dii_package;

    localparam int DII_DATA_W = 16;
    localparam int DII_HDR_W  = 16;

    typedef struct packed {
        logic [DII_DATA_W-1:0] data;
        logic                  last;
        logic                  valid;
    } dii_flit;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } pktz_state_e;

endpackage

// File: rtl/dii_skid_buffer.sv
// Two-entry FIFO output stage for a DII port; out_flit is driven straight from a register.
// Latency: a flit pushed in cycle t is visible on out_flit in cycle t+1.
// Backpressure: full is a registered flag (no path from out_ready); push and pop may coincide.
//
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   in_flit    - flit to enqueue; in_flit.valid is the push strobe (ignored while full)
//   full       - both entries occupied
//   out_flit   - head entry; out_flit.valid=0 when empty
//   out_ready  - downstream accepts the head entry
module dii_skid_buffer
    import dii_package::*;
#(
    parameter type flit_t = dii_flit
)
(
    input  logic  clk,
    input  logic  rst,
    input  flit_t in_flit,
    output logic  full,
    output flit_t out_flit,
    input  logic  out_ready
);

    flit_t      head_q;
    flit_t      tail_q;
    logic [1:0] count_q;
    logic       push;
    logic       pop;

    assign full     = (count_q == 2'd2);
    assign push     = in_flit.valid && !full;
    assign pop      = head_q.valid && out_ready;
    assign out_flit = head_q;

    // head_q.valid tracks "occupancy != 0" so the head register alone drives the port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    // Push is only possible with one entry here, so the new flit
                    // lands directly in the head as the old head leaves.
                    head_q <= in_flit;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= in_flit;
                    end else begin
                        tail_q <= in_flit;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                    end else begin
                        head_q.valid <= 1'b0;
                    end
                    count_q <= count_q - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/dii_host_packetizer.sv
// Turns the length-prefixed GLIP host word stream into DII flits with a last marker, dropping malformed packets.
// Latency: payload word accepted in cycle t appears on dii_out in cycle t+1; headers are never forwarded.
// Backpressure: glip_in_ready falls only in FWD with the output buffer full; IDLE and DROP always accept.
//
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   glip_in_*      - host word stream (data/valid/ready)
//   dii_out        - outgoing flit {data, last, valid}, registered
//   dii_out_ready  - downstream accepts the flit
//   drop_pulse     - one cycle high after a rejected header
//   drop_cnt       - saturating count of rejected packets
module dii_host_packetizer
    import dii_package::*;
#(
    parameter int MAX_PKT_LEN = 12,
    parameter int DROP_CNT_W  = 16
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           glip_in_data,
    input  logic                  glip_in_valid,
    output logic                  glip_in_ready,
    output dii_flit               dii_out,
    input  logic                  dii_out_ready,
    output logic                  drop_pulse,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [DII_HDR_W-1:0] MAX_LEN = DII_HDR_W'(MAX_PKT_LEN);

    pktz_state_e          state_q;
    logic [DII_HDR_W-1:0] rem_q;
    logic                 ready_en_q;
    logic                 skid_full;
    logic                 word_xfer;
    dii_flit              push_flit;

    // ready_en_q keeps glip_in_ready low while in reset and for the first edge after release.
    assign glip_in_ready = ready_en_q && !((state_q == ST_FWD) && skid_full);
    assign word_xfer     = glip_in_valid && glip_in_ready;

    always_comb begin
        push_flit       = '0;
        push_flit.data  = glip_in_data;
        push_flit.last  = (rem_q == DII_HDR_W'(1));
        push_flit.valid = word_xfer && (state_q == ST_FWD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            ready_en_q <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            ready_en_q <= 1'b1;
            drop_pulse <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (word_xfer) begin
                        if (glip_in_data == '0) begin
                            drop_pulse <= 1'b1;
                            if (drop_cnt != '1) begin
                                drop_cnt <= drop_cnt + 1'b1;
                            end
                        end else if (glip_in_data > MAX_LEN) begin
                            // Oversized packet: swallow its payload so the host stream stays framed.
                            state_q    <= ST_DROP;
                            rem_q      <= glip_in_data;
                            drop_pulse <= 1'b1;
                            if (drop_cnt != '1) begin
                                drop_cnt <= drop_cnt + 1'b1;
                            end
                        end else begin
                            state_q <= ST_FWD;
                            rem_q   <= glip_in_data;
                        end
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (word_xfer) begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == DII_HDR_W'(1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    dii_skid_buffer #(
        .flit_t (dii_flit)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (push_flit),
        .full      (skid_full),
        .out_flit  (dii_out),
        .out_ready (dii_out_ready)
    );

endmodule
